// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - owner ids, FSM state encoding and latched AR request type
package axi_rd_arbiter_pkg;

  localparam logic AXI_INST_Id = 1'b0;
  localparam logic AXI_DATA_Id = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AR     = 3'd1,
    ST_R_INST = 3'd2,
    ST_R_DATA = 3'd3,
    ST_GAP    = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ar_req_t;

  // rr_prio names the side that wins the next collision
  function automatic logic pick_owner(input logic i_req, input logic d_req, input logic rr_prio);
    if (i_req && d_req) return rr_prio;
    return d_req ? AXI_DATA_Id : AXI_INST_Id;
  endfunction

endpackage

// File: rtl/axi_beat_cnt.sv
// rtl/axi_beat_cnt.sv - R beat counter flagging rlast position and rid mismatches (sticky err)
module axi_beat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] len,
  input  logic       beat,
  input  logic       rlast,
  input  logic [3:0] rid,
  input  logic [3:0] exp_id,
  output logic       err
);

  logic [3:0] remaining;
  logic       bad;

  // rlast must coincide exactly with the final counted beat
  assign bad = beat && ((rlast != (remaining == 4'd0)) || (rid != exp_id));

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= 4'd0;
      err       <= 1'b0;
    end else begin
      if (load) remaining <= len;
      else if (beat && (remaining != 4'd0)) remaining <= remaining - 4'd1;
      if (bad) err <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - inst/data AXI read arbiter, one outstanding read; AXI_RD_BEAT_CHECK_EN adds beat checking
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_arid,
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  input  logic [1:0]  i_arlock,
  input  logic [3:0]  i_arcache,
  input  logic [2:0]  i_arprot,
  input  logic        i_arvalid,
  output logic [3:0]  i_rid,
  output logic [31:0] i_rdata,
  output logic [1:0]  i_rresp,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic [3:0]  d_arid,
  input  logic [31:0] d_araddr,
  input  logic [3:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic [1:0]  d_arburst,
  input  logic [1:0]  d_arlock,
  input  logic [3:0]  d_arcache,
  input  logic [2:0]  d_arprot,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [3:0]  d_rid,
  output logic [31:0] d_rdata,
  output logic [1:0]  d_rresp,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [1:0]  m_arlock,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        rd_err
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  arb_state_t state, state_nxt;
  ar_req_t    ar_q, i_req, d_req;
  logic       owner_q, rr_prio, grant, grant_owner;
  logic [7:0] gap_cnt;

  assign i_req = {i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arlock, i_arcache, i_arprot};
  assign d_req = {d_arid, d_araddr, d_arlen, d_arsize, d_arburst, d_arlock, d_arcache, d_arprot};

  assign grant       = (state == ST_IDLE) && (i_arvalid || d_arvalid);
  assign grant_owner = pick_owner(i_arvalid, d_arvalid, rr_prio);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant) state_nxt = ST_AR;
      ST_AR:     if (m_arready) state_nxt = (owner_q == AXI_DATA_Id) ? ST_R_DATA : ST_R_INST;
      ST_R_INST: if (m_rvalid && m_rlast) state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_R_DATA: if (m_rvalid && d_rready && m_rlast) state_nxt = ST_IDLE;
      ST_GAP:    if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Priority only flips on contested grants, so back-to-back collisions alternate
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q    <= '0;
      owner_q <= AXI_INST_Id;
      rr_prio <= AXI_DATA_Id;
      gap_cnt <= 8'd0;
    end else begin
      if (grant) begin
        ar_q    <= (grant_owner == AXI_DATA_Id) ? d_req : i_req;
        owner_q <= grant_owner;
        if (i_arvalid && d_arvalid) rr_prio <= ~grant_owner;
      end
      if (state == ST_GAP) gap_cnt <= gap_cnt + 8'd1;
      else                 gap_cnt <= 8'd0;
    end
  end

  always_comb begin
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    i_rid     = 4'd0;
    i_rdata   = 32'd0;
    i_rresp   = 2'd0;
    i_rlast   = 1'b0;
    d_rvalid  = 1'b0;
    d_rid     = 4'd0;
    d_rdata   = 32'd0;
    d_rresp   = 2'd0;
    d_rlast   = 1'b0;
    case (state)
      ST_IDLE: d_arready = !rst && grant && (grant_owner == AXI_DATA_Id);
      ST_AR:   m_arvalid = 1'b1;
      ST_R_INST: begin
        m_rready = 1'b1;
        i_rvalid = m_rvalid;
        i_rid    = m_rid;
        i_rdata  = m_rdata;
        i_rresp  = m_rresp;
        i_rlast  = m_rlast;
      end
      ST_R_DATA: begin
        m_rready = d_rready;
        d_rvalid = m_rvalid;
        d_rid    = m_rid;
        d_rdata  = m_rdata;
        d_rresp  = m_rresp;
        d_rlast  = m_rlast;
      end
      default: ;
    endcase
  end

  assign m_arid    = ar_q.id;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;
  assign m_arlock  = ar_q.lock;
  assign m_arcache = ar_q.cache;
  assign m_arprot  = ar_q.prot;

`ifdef AXI_RD_BEAT_CHECK_EN
  logic cnt_load, cnt_beat;

  assign cnt_load = (state == ST_AR) && m_arready;
  assign cnt_beat = ((state == ST_R_INST) || (state == ST_R_DATA)) && m_rvalid && m_rready;

  axi_beat_cnt u_beat_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .len    (ar_q.len),
    .beat   (cnt_beat),
    .rlast  (m_rlast),
    .rid    (m_rid),
    .exp_id (ar_q.id),
    .err    (rd_err)
  );
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel arbiter between the instruction-fetch AXI port and the data-side AXI read port, driving the single AXI read master of the core. It latches one AR request at a time, keeps `m_arvalid` stable until `m_arready`, then steers R beats back to the owning requester by state. The instruction side has no `arready`/`rready`, so the arbiter absorbs a level-held `i_arvalid` and always accepts instruction beats. Exactly one read transaction is outstanding at any time.

## Interface
Parameters:
- `GAP_CYCLES`, 1: idle cycles after an instruction burst completes before `i_arvalid` is sampled again. This covers the cache hit/miss update.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `i_arid/i_araddr/i_arlen/i_arsize/i_arburst/i_arlock/i_arcache/i_arprot`  in  4/32/4/3/2/2/4/3  instruction AR fields
- `i_arvalid`  in  1  instruction request, level-held, no ready
- `i_rid/i_rdata/i_rresp/i_rlast/i_rvalid`  out  4/32/2/1/1  instruction R beats, always accepted
- `d_ar*` (same eight fields)  in  data AR fields
- `d_arvalid`  in  1  data request
- `d_arready`  out  1  data request accepted
- `d_rid/d_rdata/d_rresp/d_rlast/d_rvalid`  out  data R beats
- `d_rready`  in  1  data side ready
- `m_ar*` (eight fields)  out  registered AR to AXI slave
- `m_arvalid`  out 1, `m_arready`  in 1
- `m_rid/m_rdata/m_rresp/m_rlast/m_rvalid`  in  R channel from slave
- `m_rready`  out  1
- `rd_err`  out  1  beat-count error, sticky (only with `AXI_RD_BEAT_CHECK_EN`)

## Operation
- States: IDLE, AR, R_INST, R_DATA, GAP.
- IDLE: picks one requester, latches its eight AR fields plus an owner bit, and goes to AR.
  - Both requesting: round-robin. The side not granted last wins; after reset, data wins.
  - Data grant: `d_arready`=1 for that single cycle.
- AR: `m_arvalid`=1 with the latched fields held constant. On `m_arready`, go to R_INST or R_DATA by owner.
- R_INST: `m_rready`=1. `i_r*` = `m_r*`, with `i_rvalid`=`m_rvalid`. On `m_rvalid & m_rlast`, go to GAP.
- R_DATA: `m_rready`=`d_rready`, and `d_r*` mirror `m_r*`. On `m_rvalid & d_rready & m_rlast`, go to IDLE.
- GAP: counts `GAP_CYCLES`, then goes to IDLE. `i_arvalid` is ignored throughout.
- Valid outputs of the non-owning side are 0 at all times.
- `i_arvalid` dropping after grant (fetch flush): the latched request is still issued and its beats are still delivered. The cache discards them.
- `rst`: all state returns to IDLE; `m_arvalid`, `m_rready`, `d_arready`, `i_rvalid`, `d_rvalid`, `rd_err` = 0; latched fields = 0. An in-flight AXI transaction is abandoned; the slave shares `rst`.

## Timing
- Request sampled in IDLE at cycle N → `m_arvalid` high at N+1.
- Slave `m_arready` at cycle M → earliest R beat is accepted at M+1.
- R path is combinational from `m_r*` to `i_r*`/`d_r*`, and from `d_rready` to `m_rready`. There are no added latency cycles.
- Instruction burst turnaround: last beat at cycle L → GAP during L+1..L+GAP_CYCLES → IDLE at L+GAP_CYCLES+1.
- `m_arvalid` never deasserts before `m_arready`. AR fields do not change while `m_arvalid`=1.

## Configuration
- `AXI_RD_BEAT_CHECK_EN` defined:
  - A 4-bit beat counter is loaded from the latched `arlen`.
  - `rd_err` is set and held until `rst` if `m_rlast` arrives early or late relative to the counter, or if `m_rid` differs from the latched id.
  - Mismatching beats are still forwarded.
- Not defined: no counter, `rd_err` tied 0, no check logic.

## Structure
- Shared defines: `AXI_INST_Id`, `AXI_DATA_Id`, and the state encoding constants.
- One sub-module, `axi_beat_cnt`. It is instantiated only under `AXI_RD_BEAT_CHECK_EN`.

## Test plan
- **Single instruction burst.** `i_araddr`=0x1FC00020, `i_arlen`=7; slave asserts `m_arready` after 2 cycles and returns 8 beats.
  - Exactly one AR is issued, with `m_araddr`=0x1FC00020.
  - 8 `i_rvalid` pulses; `d_rvalid` stays 0.
  - `i_arvalid` held through GAP produces no second AR.
- **Simultaneous requests after reset.** `d_arvalid` and `i_arvalid` asserted together.
  - Data is issued first (`d_arready` pulses once), then instruction.
  - Repeating the collision issues instruction first.
- **Data backpressure.** Data read with `arlen`=0 and `d_rready` low for 3 cycles.
  - `m_rready` stays low for those 3 cycles; beat delivered on the 4th; back to IDLE.
- **Flush mid-request.** `i_arvalid` dropped while in AR with `m_arready`=0.
  - `m_arvalid` and `m_araddr` stay stable until accepted; all 8 beats are still forwarded.
- **Reset mid-burst.** `rst` asserted after beat 3 of an instruction burst.
  - All outputs are 0 the next cycle and the arbiter is in IDLE.
- **Beat check (macro on).** `arlen`=7 with `m_rlast` on beat 5 → `rd_err`=1 and sticky until `rst`.
